piso_serializer: RTL and testbench

Parallel-in/serial-out stage that feeds the sequence-detector FSMs: it accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on `x`, qualified by `x_valid`. It sits directly upstream of the detector, whose `x` input it drives. Back-to-back words stream with no bubble cycle, so a bit pattern spanning a word boundary is presented contiguously to the detector.

---
 rtl/piso_serializer_pkg.sv | 22 ++
 rtl/piso_serializer_bit_counter.sv | 49 ++++
 rtl/piso_serializer.sv | 114 +++++++++++
 tb/tb_piso_serializer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serializer and its bit counter: FSM state
// encoding (matching the detector FSMs) and a clog2 helper for sizing.
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Number of bits needed to hold values 0..value-1 (at least 1).
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Bit position counter for the serializer. Counts 0..WIDTH-1 while
// enabled, reloads 0 explicitly after WIDTH-1, and can be cleared
// synchronously when a new word is loaded. terminal flags WIDTH-1.
module bit_counter
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] TERM_COUNT = CW'(WIDTH - 1);

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_s;

  assign terminal = (count_r == TERM_COUNT);

  // Next count: clear wins, otherwise step with explicit wrap at WIDTH-1.
  always_comb begin
    count_s = count_r;
    if (clear) begin
      count_s = '0;
    end else if (enable) begin
      if (terminal) begin
        count_s = '0;
      end else begin
        count_s = count_r + CW'(1);
      end
    end else begin
      count_s = count_r;
    end
  end

  // Count register with asynchronous reset to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else begin
      count_r <= count_s;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding the sequence detectors. A word is
// taken over a valid/ready handshake and sent one bit per clock on x.
// A new word may be accepted during the last bit of the current one, so
// consecutive words stream with no gap in x_valid.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             done
);

  state_e           state_r;
  state_e           state_s;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shift_s;
  logic [WIDTH-1:0] shifted_s;
  logic             terminal_s;
  logic             accept_s;
  logic             shifting_s;

  assign shifting_s = (state_r == ST_SHIFT);
  assign accept_s   = load_valid && load_ready;

  // The vacated end of the register always fills with zero, so the
  // register is empty again once the last bit has been shifted out.
  assign shifted_s = (MSB_FIRST != 0) ? {shift_r[WIDTH-2:0], 1'b0}
                                      : {1'b0, shift_r[WIDTH-1:1]};

  bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept_s),
    .enable  (shifting_s),
    .terminal(terminal_s)
  );

  // Output decode from registered state and count only; ready never
  // looks at load_valid, and x is forced low outside of SHIFT.
  always_comb begin
    load_ready = 1'b0;
    x_valid    = 1'b0;
    x          = 1'b0;
    done       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        load_ready = 1'b1;
      end
      ST_SHIFT: begin
        load_ready = terminal_s;
        x_valid    = 1'b1;
        x          = (MSB_FIRST != 0) ? shift_r[WIDTH-1] : shift_r[0];
        done       = terminal_s;
      end
      default: begin
        load_ready = 1'b1;
      end
    endcase
  end

  // Next-state and shift register update; unknown states fall back to IDLE.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_SHIFT;
          shift_s = data_in;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (accept_s) begin
          state_s = ST_SHIFT;
          shift_s = data_in;
        end else if (terminal_s) begin
          state_s = ST_IDLE;
          shift_s = shifted_s;
        end else begin
          state_s = ST_SHIFT;
          shift_s = shifted_s;
        end
      end
      default: begin
        state_s = ST_IDLE;
        shift_s = '0;
      end
    endcase
  end

  // State and shift registers; reset abandons any word in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      shift_r <= '0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: one MSB-first and one LSB-first instance share
// the stimulus. A queue of pending bits per instance predicts every output.
module tb_piso_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       load_valid;
  logic       rdy_m, x_m, xv_m, dn_m;
  logic       rdy_l, x_l, xv_l, dn_l;
  logic [7:0] obs;

  int n_cmp;
  int n_err;

  bit qm[$];
  bit ql[$];

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(rdy_m), .x(x_m), .x_valid(xv_m), .done(dn_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(rdy_l), .x(x_l), .x_valid(xv_l), .done(dn_l)
  );

  assign obs = {x_m, xv_m, dn_m, rdy_m, x_l, xv_l, dn_l, rdy_l};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs: front of the queue is the bit on the wire, a single
  // remaining bit is the last one (done, ready), empty means idle.
  function automatic logic [7:0] exp_vec();
    logic [3:0] em;
    logic [3:0] el;
    em = {(qm.size() > 0) ? logic'(qm[0]) : 1'b0, qm.size() > 0,
          qm.size() == 1, qm.size() <= 1};
    el = {(ql.size() > 0) ? logic'(ql[0]) : 1'b0, ql.size() > 0,
          ql.size() == 1, ql.size() <= 1};
    return {em, el};
  endfunction

  // Drive inputs for one cycle, update the model at the edge, and return
  // at the following falling edge where outputs are stable.
  task automatic advance(input logic lv, input logic [7:0] d);
    bit acc;
    load_valid = lv;
    data_in    = d;
    acc = lv && (qm.size() <= 1);
    @(posedge clk);
    if (qm.size() > 0) void'(qm.pop_front());
    if (ql.size() > 0) void'(ql.pop_front());
    if (acc) begin
      for (int i = 0; i < 8; i++) begin
        qm.push_back(d[7-i]);
        ql.push_back(d[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load_valid = 1'b0;
    data_in = 8'h00;
    qm.delete();
    ql.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== 8'h11) begin
        n_err++;
        $display("FAIL reset_hold cyc %0d got %b exp %b", i, obs, 8'h11);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      advance(1'b0, 8'h00);
      n_cmp++;
      if (obs !== 8'h11) begin
        n_err++;
        $display("FAIL reset_idle cyc %0d got %b exp %b", i, obs, 8'h11);
      end
    end
  endtask

  task automatic test_single_msb();
    logic [7:0] stream;
    int done_cnt;
    int done_at;
    stream = 8'h00;
    done_cnt = 0;
    done_at = -1;
    advance(1'b1, 8'hA5);
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL single_msb cyc %0d got %b exp %b", i, obs, exp_vec());
      end
      if (i < 8) stream[7-i] = x_m;
      if (dn_m) begin
        done_cnt++;
        done_at = i;
      end
      advance(1'b0, 8'h00);
    end
    n_cmp++;
    if (stream !== 8'hA5 || done_cnt != 1 || done_at != 7) begin
      n_err++;
      $display("FAIL single_msb_seq got %h done %0d@%0d exp a5 done 1@7",
               stream, done_cnt, done_at);
    end
  endtask

  task automatic test_lsb();
    logic [7:0] stream;
    logic [2:0] win;
    int hits;
    stream = 8'h00;
    win = 3'b000;
    hits = 0;
    advance(1'b1, 8'h0D);
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL lsb cyc %0d got %b exp %b", i, obs, exp_vec());
      end
      if (xv_l) begin
        stream[i] = x_l;
        win = {win[1:0], x_l};
        if (i >= 2 && win == 3'b101) hits++;
      end
      advance(1'b0, 8'h00);
    end
    n_cmp++;
    if (stream !== 8'h0D || hits != 1) begin
      n_err++;
      $display("FAIL lsb_seq got %h hits %0d exp 0d hits 1", stream, hits);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream;
    int valid_cnt;
    int rdy_mask;
    stream = 16'h0000;
    valid_cnt = 0;
    rdy_mask = 0;
    advance(1'b1, 8'h81);
    for (int i = 0; i < 17; i++) begin
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL b2b cyc %0d got %b exp %b", i, obs, exp_vec());
      end
      if (i < 16) begin
        stream[15-i] = x_m;
        if (xv_m) valid_cnt++;
        if (rdy_m) rdy_mask = rdy_mask | (1 << i);
      end
      advance(i <= 7, 8'h40);
    end
    n_cmp++;
    if (stream !== 16'h8140 || valid_cnt != 16 || rdy_mask != 32'h8080) begin
      n_err++;
      $display("FAIL b2b_seq got %h valid %0d rdy %h exp 8140 16 8080",
               stream, valid_cnt, rdy_mask);
    end
  endtask

  task automatic test_hold_off();
    int valid_cnt;
    valid_cnt = 0;
    advance(1'b1, 8'h3C);
    for (int i = 0; i < 17; i++) begin
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL hold_off cyc %0d got %b exp %b", i, obs, exp_vec());
      end
      if (i < 16 && xv_m) valid_cnt++;
      advance(i >= 3 && i <= 7, 8'hFF);
    end
    n_cmp++;
    if (valid_cnt != 16) begin
      n_err++;
      $display("FAIL hold_off_gap got %0d valid cycles exp 16", valid_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    advance(1'b1, 8'hFF);
    for (int i = 0; i < 4; i++) advance(1'b0, 8'h00);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 8'h11) begin
      n_err++;
      $display("FAIL reset_mid got %b exp %b", obs, 8'h11);
    end
    qm.delete();
    ql.delete();
    @(negedge clk);
    reset = 1'b0;
    w = 8'($urandom);
    advance(1'b1, w);
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL reset_resume cyc %0d got %b exp %b", i, obs, exp_vec());
      end
      advance(1'b0, 8'h00);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      advance($urandom_range(0, 3) != 0, 8'($urandom));
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL random cyc %0d got %b exp %b", i, obs, exp_vec());
      end
    end
    for (int i = 0; i < 10; i++) begin
      advance(1'b0, 8'h00);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++;
        $display("FAIL drain cyc %0d got %b exp %b", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    load_valid = 1'b0;
    data_in = 8'h00;
    test_reset();
    test_single_msb();
    test_lsb();
    test_back_to_back();
    test_hold_off();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
